// File: rtl/vrvv_pkg.sv
// Shared vector-register constants and types for the vector pipeline blocks.
package vrvv_pkg;
    localparam int NUM_VREGS = 32;
    localparam int VRIDX_W   = 5;
    localparam int LAT_W     = 3;

    localparam int LAT_VALU  = 1;
    localparam int LAT_VLOAD = 2;
    localparam int LAT_VMUL  = 3;

    typedef logic [VRIDX_W-1:0] vreg_idx_t;
    typedef logic [LAT_W-1:0]   vlat_t;

    // A zero latency still needs one cycle to reach the bypass path.
    function automatic vlat_t clampLat(input vlat_t lat);
        return (lat == '0) ? vlat_t'(1) : lat;
    endfunction
endpackage

// File: rtl/vhazard_entry.sv
// One scoreboard slot: pending flag plus latency countdown for a single vector register.
module vhazard_entry
    import vrvv_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  alloc,
    input  vlat_t allocLat,
    input  logic  clear,
    output logic  pend,
    output logic  busy
);
    vlat_t cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else if (alloc) begin
            pend <= 1'b1;
            cnt  <= allocLat;
        end else if (clear) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else if (cnt != '0) begin
            cnt  <= cnt - vlat_t'(1);
        end
    end

    // The consumer in ID reads its operand one edge later, after this cycle's
    // decrement, so a count of 1 is already bypassable by then.
    assign busy = pend && (cnt > vlat_t'(1));
endmodule

// File: rtl/vhazard_scoreboard.sv
// Vector RAW/WAW hazard scoreboard beside the ID/EX register.
// Optional VHAZARD_STATS_EN adds a saturating stall_cycles counter output.
module vhazard_scoreboard
    import vrvv_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [VRIDX_W-1:0]   id_vrs1,
    input  logic [VRIDX_W-1:0]   id_vrs2,
    input  logic                 id_uses_vrs1,
    input  logic                 id_uses_vrs2,
    input  logic                 id_writes_vrd,
    input  logic [VRIDX_W-1:0]   id_vrd,
    input  logic [LAT_W-1:0]     id_lat,
    input  logic                 id_flush,
    input  logic                 wb_valid,
    input  logic [VRIDX_W-1:0]   wb_vrd,
    output logic                 id_ready,
    output logic                 stall_vrs1,
    output logic                 stall_vrs2,
`ifdef VHAZARD_STATS_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic [NUM_VREGS-1:0] pending_vec
);
    logic [NUM_VREGS-1:0] busyVec;
    logic                 waw;
    logic                 issue;
    vlat_t                allocLat;

    assign stall_vrs1 = id_valid & id_uses_vrs1  & busyVec[id_vrs1];
    assign stall_vrs2 = id_valid & id_uses_vrs2  & busyVec[id_vrs2];
    assign waw        = id_valid & id_writes_vrd & busyVec[id_vrd];
    assign id_ready   = ~(stall_vrs1 | stall_vrs2 | waw);
    assign issue      = id_valid & id_ready & ~id_flush;
    assign allocLat   = clampLat(id_lat);

    genvar i;
    generate
        for (i = 0; i < NUM_VREGS; i++) begin : gEntry
            logic allocHit;
            logic clearHit;
            assign allocHit = issue & id_writes_vrd & (id_vrd == vreg_idx_t'(i));
            assign clearHit = wb_valid & (wb_vrd == vreg_idx_t'(i));

            vhazard_entry uEntry (
                .clock    (clock),
                .reset    (reset),
                .alloc    (allocHit),
                .allocLat (allocLat),
                .clear    (clearHit),
                .pend     (pending_vec[i]),
                .busy     (busyVec[i])
            );
        end
    endgenerate

`ifdef VHAZARD_STATS_EN
    // Flushed instructions are not counted even while they see a hazard.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (id_valid & ~id_ready & ~id_flush & (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_vhazard_scoreboard.sv
// Directed bench for vhazard_scoreboard; covers stats counter when VHAZARD_STATS_EN is defined.
module tb_vhazard_scoreboard;
    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_vrs1, id_uses_vrs2, id_writes_vrd, id_flush, wb_valid;
    logic [4:0]  id_vrs1, id_vrs2, id_vrd, wb_vrd;
    logic [2:0]  id_lat;
    logic        id_ready, stall_vrs1, stall_vrs2;
    logic [31:0] pending_vec;
`ifdef VHAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif
    int checks = 0;
    int errors = 0;

    vhazard_scoreboard dut (
        .clock         (clock),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_vrs1       (id_vrs1),
        .id_vrs2       (id_vrs2),
        .id_uses_vrs1  (id_uses_vrs1),
        .id_uses_vrs2  (id_uses_vrs2),
        .id_writes_vrd (id_writes_vrd),
        .id_vrd        (id_vrd),
        .id_lat        (id_lat),
        .id_flush      (id_flush),
        .wb_valid      (wb_valid),
        .wb_vrd        (wb_vrd),
        .id_ready      (id_ready),
        .stall_vrs1    (stall_vrs1),
        .stall_vrs2    (stall_vrs2),
`ifdef VHAZARD_STATS_EN
        .stall_cycles  (stall_cycles),
`endif
        .pending_vec   (pending_vec)
    );

    always #5 clock = ~clock;

    task automatic idle();
        id_valid = 0; id_uses_vrs1 = 0; id_uses_vrs2 = 0; id_writes_vrd = 0;
        id_flush = 0; wb_valid = 0; id_vrs1 = 0; id_vrs2 = 0; id_vrd = 0;
        id_lat = 0; wb_vrd = 0;
    endtask

    // Advance to 1ns after the next rising edge, with ID idle.
    task automatic tick();
        @(posedge clock); #1;
        idle();
    endtask

    task automatic issueWrite(input logic [4:0] vrd, input logic [2:0] lat);
        id_valid = 1; id_writes_vrd = 1; id_vrd = vrd; id_lat = lat;
    endtask

    task automatic test_reset_init();
        idle(); reset = 1; #2;
        checks++; if (pending_vec !== 32'h0) begin errors++; $display("FAIL init_pending got %0h want 0", pending_vec); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL init_ready got %0b want 1", id_ready); end
        checks++; if ({stall_vrs1, stall_vrs2} !== 2'b00) begin errors++; $display("FAIL init_stall got %0b want 00", {stall_vrs1, stall_vrs2}); end
`ifdef VHAZARD_STATS_EN
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL init_stats got %0d want 0", stall_cycles); end
`endif
        @(posedge clock); #1; reset = 0;
    endtask

    task automatic test_back_to_back();
        issueWrite(5'd3, 3'd1); #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_issue_ready got %0b want 1", id_ready); end
        tick();
        id_valid = 1; id_uses_vrs1 = 1; id_vrs1 = 5'd3; #1;
        checks++; if (pending_vec[3] !== 1'b1) begin errors++; $display("FAIL b2b_pend3 got %0b want 1", pending_vec[3]); end
        checks++; if (stall_vrs1 !== 1'b0) begin errors++; $display("FAIL b2b_stall1 got %0b want 0", stall_vrs1); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b want 1", id_ready); end
        tick();
    endtask

    task automatic test_load_use();
        issueWrite(5'd5, 3'd2);
        tick();
        id_valid = 1; id_uses_vrs2 = 1; id_vrs2 = 5'd5; #1;
        checks++; if ({stall_vrs1, stall_vrs2, id_ready} !== 3'b010) begin errors++; $display("FAIL loaduse_c1 got %0b want 010", {stall_vrs1, stall_vrs2, id_ready}); end
        @(posedge clock); #2;
        checks++; if ({stall_vrs2, id_ready} !== 2'b01) begin errors++; $display("FAIL loaduse_c2 got %0b want 01", {stall_vrs2, id_ready}); end
        tick();
    endtask

    task automatic test_waw();
        issueWrite(5'd7, 3'd3);
        tick();
        issueWrite(5'd7, 3'd1); #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL waw_c1 got %0b want 0", id_ready); end
        @(posedge clock); #2;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL waw_c2 got %0b want 0", id_ready); end
        @(posedge clock); #2;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL waw_c3 got %0b want 1", id_ready); end
        tick(); #1;
        checks++; if (pending_vec[7] !== 1'b1) begin errors++; $display("FAIL waw_pend7 got %0b want 1", pending_vec[7]); end
    endtask

    task automatic test_same_edge();
        issueWrite(5'd9, 3'd1);
        tick();
        issueWrite(5'd9, 3'd2); wb_valid = 1; wb_vrd = 5'd9; #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %0b want 1", id_ready); end
        tick();
        id_valid = 1; id_uses_vrs1 = 1; id_vrs1 = 5'd9; #1;
        checks++; if (pending_vec[9] !== 1'b1) begin errors++; $display("FAIL same_pend9 got %0b want 1", pending_vec[9]); end
        checks++; if (stall_vrs1 !== 1'b1) begin errors++; $display("FAIL same_cnt2_stall got %0b want 1", stall_vrs1); end
        @(posedge clock); #2;
        checks++; if (stall_vrs1 !== 1'b0) begin errors++; $display("FAIL same_cnt1_stall got %0b want 0", stall_vrs1); end
        idle(); wb_valid = 1; wb_vrd = 5'd9;
        tick();
        wb_valid = 1; wb_vrd = 5'd9;
        tick(); #1;
        checks++; if (pending_vec !== 32'h0000_00A8) begin errors++; $display("FAIL wb_clear got %0h want a8", pending_vec); end
    endtask

    task automatic test_lat_zero_and_alias();
        issueWrite(5'd11, 3'd0);
        tick();
        id_valid = 1; id_uses_vrs1 = 1; id_vrs1 = 5'd11; #1;
        checks++; if ({pending_vec[11], stall_vrs1} !== 2'b10) begin errors++; $display("FAIL lat0 got %0b want 10", {pending_vec[11], stall_vrs1}); end
        idle(); issueWrite(5'd16, 3'd2);
        tick();
        issueWrite(5'd16, 3'd1); id_uses_vrs1 = 1; id_uses_vrs2 = 1; id_vrs1 = 5'd16; id_vrs2 = 5'd16; #1;
        checks++; if ({stall_vrs1, stall_vrs2, id_ready} !== 3'b110) begin errors++; $display("FAIL alias got %0b want 110", {stall_vrs1, stall_vrs2, id_ready}); end
        tick();
    endtask

    task automatic test_flush();
        issueWrite(5'd12, 3'd3);
        tick();
        issueWrite(5'd13, 3'd2); id_flush = 1; id_uses_vrs1 = 1; id_vrs1 = 5'd12; #1;
        checks++; if ({stall_vrs1, id_ready} !== 2'b10) begin errors++; $display("FAIL flush_stall got %0b want 10", {stall_vrs1, id_ready}); end
        tick();
        issueWrite(5'd14, 3'd2); id_flush = 1; #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", id_ready); end
        tick(); #1;
        checks++; if (pending_vec[14:13] !== 2'b00) begin errors++; $display("FAIL flush_noalloc got %0b want 00", pending_vec[14:13]); end
`ifdef VHAZARD_STATS_EN
        checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL stats_count got %0d want 5", stall_cycles); end
`endif
    endtask

    task automatic test_reset_mid();
        issueWrite(5'd20, 3'd3);
        tick();
        id_valid = 1; id_uses_vrs1 = 1; id_vrs1 = 5'd20; #1;
        checks++; if (stall_vrs1 !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %0b want 1", stall_vrs1); end
        #2 reset = 1; #1;
        checks++; if (pending_vec !== 32'h0) begin errors++; $display("FAIL rst_pending got %0h want 0", pending_vec); end
        checks++; if ({id_ready, stall_vrs1} !== 2'b10) begin errors++; $display("FAIL rst_ready got %0b want 10", {id_ready, stall_vrs1}); end
`ifdef VHAZARD_STATS_EN
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stats got %0d want 0", stall_cycles); end
`endif
        @(posedge clock); #1; reset = 0;
        tick();
    endtask

    initial begin
        test_reset_init();
        test_back_to_back();
        test_load_use();
        test_waw();
        test_same_edge();
        test_lat_zero_and_alias();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
